// File: rtl/frame_packer_if.sv
// Pixel-stream input and data-memory write port of the frame packer.
// The master drives pixels and observes writes; the slave is the packer itself.
interface frame_packer_if #(
    parameter int IN_W   = 12,
    parameter int WORD_W = 256,
    parameter int ADDR_W = 7
);
    logic [IN_W-1:0]   iDATA;
    logic              iDVAL;
    logic              iFVAL;
    logic              dmem_wren;
    logic [ADDR_W-1:0] dmem_wraddr;
    logic [WORD_W-1:0] dmem_wrdata;

    modport master (
        output iDATA, iDVAL, iFVAL,
        input  dmem_wren, dmem_wraddr, dmem_wrdata
    );

    modport slave (
        input  iDATA, iDVAL, iFVAL,
        output dmem_wren, dmem_wraddr, dmem_wrdata
    );
endinterface

// File: rtl/frame_packer.sv
// Captures one IMG_W x IMG_H frame and packs PIX_W-bit pixels into WORD_W-bit words; a word is written
// the cycle after its last pixel. No backpressure: a pixel may be accepted every cycle.
module frame_packer #(
    parameter int IN_W      = 12,
    parameter int PIX_W     = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int WORD_W    = 256,
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0,
    parameter int MSB_FIRST = 0
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    input  logic           enable,
    frame_packer_if.slave  px,
    output logic           ccd_done,
    output logic           short_frame,
    output logic           busy
);
    localparam int PPW    = WORD_W / PIX_W;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int CNT_W  = $clog2(NPIX + 1);
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CAPTURE, S_FLUSH, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                fval_q;
    logic [CNT_W-1:0]    pix_cnt_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [SLOT_W-1:0]   slot_pos;
    logic [WORD_W-1:0]   word_q, word_ins;
    logic [ADDR_W-1:0]   addr_q;
    logic                wren_q;
    logic [ADDR_W-1:0]   wraddr_q;
    logic [WORD_W-1:0]   wrdata_q;
    logic [PIX_W-1:0]    pix;
    logic                fval_rise, fval_fall;
    logic                accept, last_pix, slot_full, early_end, has_data, do_write;

    if (IN_W > PIX_W) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^px.iDATA[IN_W-PIX_W-1:0];
    end

    assign pix       = px.iDATA[IN_W-1 -: PIX_W];
    assign fval_rise = px.iFVAL & ~fval_q;
    assign fval_fall = ~px.iFVAL & fval_q;

    // The rising-edge cycle itself may carry pixel 0; anything earlier belongs to a frame already running.
    assign accept    = enable & px.iDVAL &
                       (((state_q == S_ARM) & fval_rise) | (state_q == S_CAPTURE));
    assign last_pix  = accept & (pix_cnt_q == CNT_W'(NPIX - 1));
    assign slot_full = accept & (slot_q == SLOT_W'(PPW - 1));
    assign early_end = enable & (state_q == S_CAPTURE) & fval_fall & ~last_pix;
    assign has_data  = accept | (slot_q != '0);
    assign do_write  = slot_full | last_pix | (early_end & has_data);

    assign slot_pos  = (MSB_FIRST != 0) ? SLOT_W'(PPW - 1) - slot_q : slot_q;

    always_comb begin
        word_ins = word_q;
        if (accept) begin
            word_ins[int'(slot_pos)*PIX_W +: PIX_W] = pix;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_ARM;
            S_ARM: begin
                if (!enable)        state_d = S_IDLE;
                else if (last_pix)  state_d = S_FLUSH;
                else if (fval_rise) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!enable)                    state_d = S_IDLE;
                else if (last_pix || early_end) state_d = S_FLUSH;
            end
            S_FLUSH:   state_d = S_DONE;
            S_DONE:    if (!enable) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == S_ARM) || (state_q == S_CAPTURE);
        ccd_done = (state_q == S_DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fval_q      <= 1'b0;
            pix_cnt_q   <= '0;
            slot_q      <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            wren_q      <= 1'b0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
            short_frame <= 1'b0;
        end else begin
            fval_q <= px.iFVAL;
            wren_q <= do_write;
            if (do_write) begin
                wrdata_q <= word_ins;
                wraddr_q <= addr_q;
                addr_q   <= addr_q + ADDR_W'(1);
            end

            if ((state_q == S_IDLE) && enable) begin
                addr_q      <= ADDR_W'(BASE_ADDR);
                short_frame <= 1'b0;
            end else if (early_end) begin
                short_frame <= 1'b1;
            end

            // Idle or aborted: the partial word is dropped, never written.
            if ((state_q == S_IDLE) || !enable) begin
                pix_cnt_q <= '0;
                slot_q    <= '0;
                word_q    <= '0;
            end else begin
                if (accept) begin
                    pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                end
                if (do_write) begin
                    slot_q <= '0;
                    word_q <= '0;
                end else if (accept) begin
                    slot_q <= slot_q + SLOT_W'(1);
                    word_q <= word_ins;
                end
            end
        end
    end

    assign px.dmem_wren   = wren_q;
    assign px.dmem_wraddr = wraddr_q;
    assign px.dmem_wrdata = wrdata_q;
endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: default build, MSB-first build and BASE_ADDR=64 build share one pixel bus.
module tb_frame_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pdata;
    logic        pdval, pfval;
    logic        en_a, en_b, en_c;
    logic        done_a, short_a, busy_a;
    logic        done_b, short_b, busy_b;
    logic        done_c, short_c, busy_c;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_packer_if if_a ();
    frame_packer_if if_b ();
    frame_packer_if if_c ();

    assign if_a.iDATA = pdata;  assign if_a.iDVAL = pdval;  assign if_a.iFVAL = pfval;
    assign if_b.iDATA = pdata;  assign if_b.iDVAL = pdval;  assign if_b.iFVAL = pfval;
    assign if_c.iDATA = pdata;  assign if_c.iDVAL = pdval;  assign if_c.iFVAL = pfval;

    frame_packer u_a (
        .iCLK(clk), .iRST_N(rst_n), .enable(en_a), .px(if_a.slave),
        .ccd_done(done_a), .short_frame(short_a), .busy(busy_a)
    );
    frame_packer #(.MSB_FIRST(1)) u_b (
        .iCLK(clk), .iRST_N(rst_n), .enable(en_b), .px(if_b.slave),
        .ccd_done(done_b), .short_frame(short_b), .busy(busy_b)
    );
    frame_packer #(.BASE_ADDR(64)) u_c (
        .iCLK(clk), .iRST_N(rst_n), .enable(en_c), .px(if_c.slave),
        .ccd_done(done_c), .short_frame(short_c), .busy(busy_c)
    );

    logic [6:0]   qa_addr[$], qc_addr[$];
    logic [255:0] qa_data[$], qb_data[$], qc_data[$];
    int           a_wr_cyc, a_done_cyc, c_wr_cyc, c_done_cyc;
    logic         a_done_prev = 1'b0, c_done_prev = 1'b0;

    always @(negedge clk) begin
        if (if_a.dmem_wren === 1'b1) begin
            qa_addr.push_back(if_a.dmem_wraddr);
            qa_data.push_back(if_a.dmem_wrdata);
            a_wr_cyc = cyc;
        end
        if (if_b.dmem_wren === 1'b1) qb_data.push_back(if_b.dmem_wrdata);
        if (if_c.dmem_wren === 1'b1) begin
            qc_addr.push_back(if_c.dmem_wraddr);
            qc_data.push_back(if_c.dmem_wrdata);
            c_wr_cyc = cyc;
        end
        if (done_a === 1'b1 && a_done_prev !== 1'b1) a_done_cyc = cyc;
        if (done_c === 1'b1 && c_done_prev !== 1'b1) c_done_cyc = cyc;
        a_done_prev = done_a;
        c_done_prev = done_c;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pixel n carries byte n[7:0]; word w holds pixels 32w..32w+31, LSB-first, zero past npix.
    function automatic logic [255:0] exp_word(input int w, input int npix);
        logic [255:0] r;
        r = '0;
        for (int s = 0; s < 32; s++) begin
            int n;
            n = w * 32 + s;
            if (n < npix) r[s*8 +: 8] = n[7:0];
        end
        return r;
    endfunction

    task automatic check_words(input string tag, input logic [6:0] qa[$], input logic [255:0] qd[$],
                               input int nexp, input int base, input int npix);
        logic [255:0] ga, gd;
        check({tag, "_nwr"}, 256'(qa.size()), 256'(nexp));
        for (int k = 0; k < nexp; k++) begin
            ga = '1;
            gd = '1;
            if (k < qa.size()) begin
                ga = 256'(qa[k]);
                gd = qd[k];
            end
            check($sformatf("%s_addr%0d", tag, k), ga, 256'(base + k));
            check($sformatf("%s_data%0d", tag, k), gd, exp_word(k, npix));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input int start, input int cnt, input bit toggle);
        for (int i = 0; i < cnt; i++) begin
            logic [7:0] b;
            b     = 8'(start + i);
            pdata = {b, 4'h0};
            pdval = 1'b1;
            step();
            if (toggle) begin
                pdval = 1'b0;
                step();
            end
        end
        pdval = 1'b0;
    endtask

    task automatic fval_off();
        pfval = 1'b0;
        pdval = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        pdata = '0; pdval = 1'b0; pfval = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        step(); step();
        check("rst_done",  256'(done_a), 256'(0));
        check("rst_short", 256'(short_a), 256'(0));
        check("rst_busy",  256'(busy_a), 256'(0));
        check("rst_wren",  256'(if_a.dmem_wren), 256'(0));
        check("rst_wdata", if_a.dmem_wrdata, 256'(0));
        rst_n = 1'b1;
        step();

        // Full frame, default build
        en_a = 1'b1; step(); step();
        qa_addr.delete(); qa_data.delete();
        pfval = 1'b1;
        pixels(0, 784, 1'b0);
        fval_off(); step(); step(); step();
        check_words("s1", qa_addr, qa_data, 25, 0, 784);
        if (qa_data.size() >= 25) begin
            check("s1_word0_lit", qa_data[0],
                  256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100);
            check("s1_word24_hi", 256'(qa_data[24][255:128]), 256'(0));
        end else begin
            check("s1_nwr_for_lit", 256'(qa_data.size()), 256'(25));
        end
        check("s1_done_lat", 256'(a_done_cyc - a_wr_cyc), 256'(1));
        check("s1_done",  256'(done_a), 256'(1));
        check("s1_short", 256'(short_a), 256'(0));
        check("s1_busy",  256'(busy_a), 256'(0));
        en_a = 1'b0; step();
        check("s1_done_clr", 256'(done_a), 256'(0));

        // MSB-first build, two pixels then frame end
        en_b = 1'b1; step(); step();
        qb_data.delete();
        pfval = 1'b1;
        pdata = 12'hABC; pdval = 1'b1; step();
        pdata = 12'h123; step();
        fval_off(); step(); step();
        check("s2_nwr", 256'(qb_data.size()), 256'(1));
        if (qb_data.size() >= 1) check("s2_word0", qb_data[0], {8'hAB, 8'h12, 240'h0});
        check("s2_short", 256'(short_b), 256'(1));
        check("s2_done",  256'(done_b), 256'(1));
        en_b = 1'b0; step();

        // Enable raised 300 pixels into a frame
        qa_addr.delete(); qa_data.delete();
        pfval = 1'b1;
        pixels(0, 300, 1'b0);
        en_a = 1'b1;
        pixels(300, 484, 1'b0);
        fval_off(); step();
        check("s3_armed_nowr", 256'(qa_data.size()), 256'(0));
        check("s3_armed_busy", 256'(busy_a), 256'(1));
        pfval = 1'b1;
        pixels(0, 784, 1'b0);
        fval_off(); step(); step(); step();
        check_words("s3", qa_addr, qa_data, 25, 0, 784);
        check("s3_done", 256'(done_a), 256'(1));
        en_a = 1'b0; step();

        // Frame ends after 40 pixels
        en_a = 1'b1; step(); step();
        qa_addr.delete(); qa_data.delete();
        pfval = 1'b1;
        pixels(0, 40, 1'b0);
        fval_off(); step(); step(); step();
        check_words("s4", qa_addr, qa_data, 2, 0, 40);
        check("s4_short", 256'(short_a), 256'(1));
        check("s4_done",  256'(done_a), 256'(1));
        en_a = 1'b0; step();

        // Abort after 100 pixels, then asynchronous reset mid-word
        en_a = 1'b1; step(); step();
        check("s5_short_clr", 256'(short_a), 256'(0));
        qa_addr.delete(); qa_data.delete();
        pfval = 1'b1;
        pixels(0, 100, 1'b0);
        en_a = 1'b0;
        pixels(100, 20, 1'b0);
        fval_off(); step(); step();
        check("s5_nwr",  256'(qa_data.size()), 256'(3));
        check("s5_busy", 256'(busy_a), 256'(0));
        check("s5_done", 256'(done_a), 256'(0));
        en_a = 1'b1; step(); step();
        pfval = 1'b1;
        pixels(0, 40, 1'b0);
        check("s5_pre_rst_busy", 256'(busy_a), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        check("s5_rst_busy",  256'(busy_a), 256'(0));
        check("s5_rst_wren",  256'(if_a.dmem_wren), 256'(0));
        check("s5_rst_waddr", 256'(if_a.dmem_wraddr), 256'(0));
        check("s5_rst_wdata", if_a.dmem_wrdata, 256'(0));
        check("s5_rst_done",  256'(done_a), 256'(0));
        pfval = 1'b0; en_a = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // BASE_ADDR=64 build with iDVAL toggling every cycle
        en_c = 1'b1; step(); step();
        qc_addr.delete(); qc_data.delete();
        pfval = 1'b1;
        pixels(0, 784, 1'b1);
        fval_off(); step(); step(); step();
        check_words("s6", qc_addr, qc_data, 25, 64, 784);
        check("s6_done_lat", 256'(c_done_cyc - c_wr_cyc), 256'(1));
        check("s6_done", 256'(done_c), 256'(1));
        en_c = 1'b0; step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_packer.md
Name: frame_packer

Overview:
Parametrised frame capture and packing engine for the camera path. It consumes the downsampled grayscale pixel stream that follows the crop stage and packs a full IMG_W x IMG_H frame into WORD_W-bit data-memory words. Capture runs under a CPU enable/done handshake. It adds frame-boundary alignment, short-frame detection, selectable pack order and a padded final word; the earlier capture top level has none of these.

Parameters:
IN_W, 12, input pixel width
PIX_W, 8, stored pixel width; the top PIX_W bits of iDATA are kept
IMG_W, 28, frame width in pixels
IMG_H, 28, frame height in pixels
WORD_W, 256, data-memory word width; must be a multiple of PIX_W
ADDR_W, 7, data-memory address width
BASE_ADDR, 0, address of the first word
MSB_FIRST, 0, pack order: 0 = pixel 0 in bits [PIX_W-1:0]; 1 = pixel 0 in the top PIX_W bits

Ports:
iCLK  in  1  pixel clock; the only clock
iRST_N  in  1  asynchronous active-low reset
enable  in  1  CPU capture request, level
iDATA  in  IN_W  pixel data
iDVAL  in  1  pixel valid
iFVAL  in  1  frame valid, level
ccd_done  out  1  frame stored, level
short_frame  out  1  last capture ended early
busy  out  1  state is ARM or CAPTURE
dmem_wren  out  1  single-cycle write strobe
dmem_wraddr  out  ADDR_W  write address
dmem_wrdata  out  WORD_W  packed word

Behaviour:
- Constants: PPW = WORD_W/PIX_W. NPIX = IMG_W*IMG_H. NWORDS = ceil(NPIX/PPW). BASE_ADDR+NWORDS must be <= 2^ADDR_W. Defaults: PPW=32, NPIX=784, NWORDS=25.
- Reset (async, iRST_N=0): state IDLE. All outputs 0. Pixel counter, slot counter, word register and address counter cleared.
- IDLE: when enable=1, go to ARM. Clear short_frame and load the address counter with BASE_ADDR.
- ARM: wait for an iFVAL rising edge (registered previous iFVAL = 0, current = 1), then go to CAPTURE. A pixel with iDVAL=1 in that rising-edge cycle is accepted. Pixels seen while in ARM before the edge are ignored, so a frame already in progress is never captured partially.
- CAPTURE: each cycle with iDVAL=1 accepts one pixel, iDATA[IN_W-1:IN_W-PIX_W], into the current slot; the slot position follows MSB_FIRST.
  - Word full: the pixel that fills slot PPW-1 makes dmem_wren=1 on the next cycle, with the complete word and the current address. The address then increments. The word register restarts clean with no cycle lost, so back-to-back pixels are allowed every cycle.
  - Frame complete: the pixel that makes the count reach NPIX ends capture.
    - If that pixel also fills the word, the single write above is the final write.
    - Otherwise the partial word is flushed on the next cycle with unused slots set to 0.
  - ccd_done rises the cycle after the final dmem_wren pulse, and the state moves to DONE.
  - Pixels arriving after NPIX are ignored.
- Early iFVAL fall in CAPTURE with count < NPIX: set short_frame=1. If the partial word is non-empty, flush it zero-padded. Then go to DONE the same way. A pixel with iDVAL=1 in the falling-edge cycle is accepted before the flush.
- DONE: ccd_done=1 and held. When enable=0, go to IDLE and clear ccd_done on the same edge. short_frame holds until the next enable.
- Abort: enable=0 during ARM or CAPTURE returns to IDLE.
  - No further writes are made.
  - The partial word is discarded.
  - ccd_done stays 0.
- dmem_wren is never high for two consecutive cycles unless consecutive words complete. dmem_wrdata and dmem_wraddr are valid only while dmem_wren=1 and hold their last value otherwise.
- Reset mid-frame: immediate return to the reset state; no write completes.

Test Plan:
- Default parameters. enable=1, one iFVAL frame of 784 pixels at iDVAL=1 with pixel n = {n[7:0],4'h0}. Required:
  - 25 writes at addresses 0..24.
  - Word 0 holds bytes 0x00..0x1F, byte k in [8k+7:8k].
  - Word 24 holds pixels 768..783 in [127:0], with [255:128]=0.
  - ccd_done=1 exactly one cycle after the 25th write.
- MSB_FIRST=1, iDATA=12'hABC for pixel 0 and 12'h123 for pixel 1. Required: word 0 [255:248]=8'hAB and [247:240]=8'h12.
- Enable raised mid-frame, 300 pixels already elapsed. Required: no writes until the next iFVAL rise, then a full 25-word capture.
- iFVAL falls after 40 pixels. Required:
  - Write 0 full.
  - Write 1 holds 8 pixels, remainder 0.
  - short_frame=1 and ccd_done=1.
- enable dropped after 100 pixels. Required: 3 writes only, state IDLE, ccd_done=0. Then iRST_N pulsed low mid-word: all outputs 0 asynchronously.
- iDVAL toggling 1-0-1 with a BASE_ADDR=64 build. Required: addresses 64..88, identical packed data to scenario 1.
